// File: rtl/vt_pkg.sv
// Shared constants, control codes and state encoding for the VT52 writer.
// Optional build macro: VT_AUTOWRAP_EN (wrap printable bytes at column 79).
package vt_pkg;

  localparam int COLS = 80;
  localparam int ROWS = 24;

  localparam logic [7:0] BLANK    = 8'h20;
  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  localparam logic [6:0] C_BS  = 7'h08;
  localparam logic [6:0] C_HT  = 7'h09;
  localparam logic [6:0] C_LF  = 7'h0A;
  localparam logic [6:0] C_CR  = 7'h0D;
  localparam logic [6:0] C_ESC = 7'h1B;

  localparam logic [6:0] K_A = 7'h41;
  localparam logic [6:0] K_B = 7'h42;
  localparam logic [6:0] K_C = 7'h43;
  localparam logic [6:0] K_D = 7'h44;
  localparam logic [6:0] K_H = 7'h48;
  localparam logic [6:0] K_J = 7'h4A;
  localparam logic [6:0] K_K = 7'h4B;
  localparam logic [6:0] K_Y = 7'h59;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_ESC,
    S_ESCY_ROW,
    S_ESCY_COL
  } state_t;

  function automatic logic [4:0] row_inc(input logic [4:0] y);
    return (y == LAST_ROW) ? 5'd0 : y + 5'd1;
  endfunction

  function automatic logic [4:0] row_dec(input logic [4:0] y);
    return (y == 5'd0) ? LAST_ROW : y - 5'd1;
  endfunction

  function automatic logic [4:0] row_add(input logic [4:0] a,
                                         input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 6'd24) ? 5'(s - 6'd24) : s[4:0];
  endfunction

endpackage

// File: rtl/vt_addr_encode.sv
// VT52 screen memory address map from physical (row, column).
// Shared with the video read path so both sides agree on the layout.
module vt_addr_encode (
  input  logic [6:0]  x,
  input  logic [4:0]  y,
  output logic [10:0] addr
);

  logic outside;

  // Columns 64..79 (and rows 24+) fold into the 0x300 holes of each bank
  assign outside = (y[4] & y[3]) | x[6];

  assign addr = outside ? {y[0], 2'b11, y[2:1], y[4:3], x[3:0]}
                        : {y[0], y[4:1], x[5:0]};

endmodule

// File: rtl/vt_char_writer.sv
// VT52 character writer: byte stream in, screen memory writes out.
// Build macro VT_AUTOWRAP_EN wraps to the next line after column 79.
module vt_char_writer
  import vt_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  output logic [10:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic [6:0]  curX,
  output logic [4:0]  curY,
  output logic [4:0]  topline
);

  state_t      state, state_n;
  logic [6:0]  clr_x, clr_x_n;
  logic [4:0]  clr_y, clr_y_n;
  logic [4:0]  end_y, end_y_n;
  logic [6:0]  row_r, row_n;
  logic [6:0]  x_n;
  logic [4:0]  y_n, top_n;

  logic        we_n;
  logic [6:0]  wr_x;
  logic [4:0]  wr_y;
  logic [7:0]  wr_data;
  logic [10:0] enc_addr;
  logic        do_lf;

  logic [6:0]  b;
  logic        xfer;
  logic [4:0]  bottom;
  logic [7:0]  tab_sum;
  logic [6:0]  tab_x;
  logic [6:0]  col_c;
  logic        unused_b7;

  assign unused_b7  = char_data[7];
  assign b          = char_data[6:0];
  assign char_ready = (state != S_CLEAR);
  assign xfer       = char_valid & char_ready;
  assign bottom     = row_add(topline, LAST_ROW);
  assign tab_sum    = {1'b0, curX | 7'd7} + 8'd1;
  assign tab_x      = (tab_sum > 8'd79) ? LAST_COL : tab_sum[6:0];
  assign col_c      = b - 7'h20;

  vt_addr_encode u_enc (
    .x    (wr_x),
    .y    (wr_y),
    .addr (enc_addr)
  );

  // Next-state, cursor, clear-pointer and write-port decode
  always_comb begin
    state_n = state;
    x_n     = curX;
    y_n     = curY;
    top_n   = topline;
    clr_x_n = clr_x;
    clr_y_n = clr_y;
    end_y_n = end_y;
    row_n   = row_r;
    we_n    = 1'b0;
    wr_x    = curX;
    wr_y    = curY;
    wr_data = BLANK;
    do_lf   = 1'b0;
    unique case (state)
      S_CLEAR: begin
        we_n = 1'b1;
        wr_x = clr_x;
        wr_y = clr_y;
        if (clr_x == LAST_COL) begin
          clr_x_n = 7'd0;
          if (clr_y == end_y) state_n = S_IDLE;
          else clr_y_n = row_inc(clr_y);
        end else begin
          clr_x_n = clr_x + 7'd1;
        end
      end
      S_IDLE: begin
        if (xfer) begin
          if (b >= 7'h20 && b != 7'h7F) begin
            we_n    = 1'b1;
            wr_data = {1'b0, b};
            if (curX != LAST_COL) x_n = curX + 7'd1;
`ifdef VT_AUTOWRAP_EN
            else begin
              x_n   = 7'd0;
              do_lf = 1'b1;
            end
`endif
          end else begin
            case (b)
              C_CR:  x_n = 7'd0;
              C_LF:  do_lf = 1'b1;
              C_BS:  if (curX != 7'd0) x_n = curX - 7'd1;
              C_HT:  x_n = tab_x;
              C_ESC: state_n = S_ESC;
              default: ;
            endcase
          end
        end
      end
      S_ESC: begin
        if (xfer) begin
          state_n = S_IDLE;
          case (b)
            K_A: if (curY != topline) y_n = row_dec(curY);
            K_B: if (curY != bottom) y_n = row_inc(curY);
            K_C: if (curX != LAST_COL) x_n = curX + 7'd1;
            K_D: if (curX != 7'd0) x_n = curX - 7'd1;
            K_H: begin
              x_n = 7'd0;
              y_n = topline;
            end
            K_J: begin
              clr_x_n = curX;
              clr_y_n = curY;
              end_y_n = bottom;
              state_n = S_CLEAR;
            end
            K_K: begin
              clr_x_n = curX;
              clr_y_n = curY;
              end_y_n = curY;
              state_n = S_CLEAR;
            end
            K_Y: state_n = S_ESCY_ROW;
            default: ;
          endcase
        end
      end
      S_ESCY_ROW: begin
        if (xfer) begin
          row_n   = b - 7'h20;
          state_n = S_ESCY_COL;
        end
      end
      S_ESCY_COL: begin
        if (xfer) begin
          if (row_r < 7'd24) y_n = row_add(topline, row_r[4:0]);
          if (col_c < 7'd80) x_n = col_c;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_CLEAR;
    endcase
    // Line feed: step down, or rotate topline and blank the reused row
    if (do_lf) begin
      if (curY != bottom) begin
        y_n = row_inc(curY);
      end else begin
        top_n   = row_inc(topline);
        y_n     = topline;
        clr_x_n = 7'd0;
        clr_y_n = topline;
        end_y_n = topline;
        state_n = S_CLEAR;
      end
    end
  end

  // State register; reset restarts the full-screen clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_CLEAR;
    else        state <= state_n;
  end

  // Cursor, clear pointers and registered memory write port
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      curX      <= 7'd0;
      curY      <= 5'd0;
      topline   <= 5'd0;
      clr_x     <= 7'd0;
      clr_y     <= 5'd0;
      end_y     <= LAST_ROW;
      row_r     <= 7'd0;
      mem_we    <= 1'b0;
      mem_addr  <= 11'd0;
      mem_wdata <= 8'd0;
    end else begin
      curX    <= x_n;
      curY    <= y_n;
      topline <= top_n;
      clr_x   <= clr_x_n;
      clr_y   <= clr_y_n;
      end_y   <= end_y_n;
      row_r   <= row_n;
      mem_we  <= we_n;
      if (we_n) begin
        mem_addr  <= enc_addr;
        mem_wdata <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_vt_char_writer.sv
// Self-checking bench for vt_char_writer: vector table, corner
// sequences and random bytes against a logical-row screen model.
module tb_vt_char_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        char_valid = 1'b0;
  logic [7:0]  char_data = 8'h00;
  logic        char_ready;
  logic [10:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [6:0]  curX;
  logic [4:0]  curY;
  logic [4:0]  topline;

  always #5 clock = ~clock;

  vt_char_writer dut (
    .clock      (clock),
    .reset      (reset),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .curX       (curX),
    .curY       (curY),
    .topline    (topline)
  );

  int          vecs = 0;
  int          bad  = 0;
  int          wcount = 0;
  logic [10:0] last_addr = '0;
  logic [7:0]  last_data = '0;
  logic [7:0]  shadow [0:2047];
  int          hits   [0:2047];

  // write monitor, samples just after each rising edge
  always @(posedge clock) begin
    #1;
    if (mem_we) begin
      shadow[mem_addr] = mem_wdata;
      hits[mem_addr]   = hits[mem_addr] + 1;
      last_addr = mem_addr;
      last_data = mem_wdata;
      wcount++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    vecs++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", n, a, e);
    end
  endtask

  function automatic int addr_of(input int x, input int y);
    if (x >= 64)
      return (y % 2) * 1024 + 768 + ((y / 2) % 4) * 64 + (y / 8) * 16 + x % 16;
    return (y % 2) * 1024 + (y / 2) * 64 + x;
  endfunction

  task automatic wait_ready(input int limit);
    int c;
    c = 0;
    while (!char_ready && c < limit) begin
      @(negedge clock);
      c++;
    end
    if (!char_ready) begin
      vecs++;
      bad++;
      $display("FAIL ready_timeout: char_ready=%0b after %0d cycles, want 1",
               char_ready, limit);
    end
  endtask

  task automatic send(input logic [7:0] d, input bit wait_done);
    wait_ready(4000);
    char_data  = d;
    char_valid = 1'b1;
    @(posedge clock);
    #1 char_valid = 1'b0;
    @(negedge clock);
    if (wait_done) wait_ready(4000);
  endtask

  task automatic do_reset_check(input string tag);
    int uniq, nblank;
    reset = 1'b0;
    #1;
    chk({tag, "_we_drop"}, 64'(mem_we), 64'd0);
    repeat (3) @(negedge clock);
    chk({tag, "_rst_state"},
        64'({mem_we, mem_addr, mem_wdata, char_ready, curX, curY, topline}),
        64'd0);
    wcount = 0;
    for (int i = 0; i < 2048; i++) begin
      hits[i]   = 0;
      shadow[i] = 8'h00;
    end
    reset = 1'b1;
    @(negedge clock);
    wait_ready(2500);
    uniq   = 0;
    nblank = 0;
    for (int i = 0; i < 2048; i++) begin
      if (hits[i] == 1) uniq++;
      if (hits[i] > 0 && shadow[i] == 8'h20) nblank++;
    end
    chk({tag, "_writes"}, 64'(wcount), 64'd1920);
    chk({tag, "_unique"}, 64'(uniq), 64'd1920);
    chk({tag, "_blank"}, 64'(nblank), 64'd1920);
    chk({tag, "_home"}, 64'({curX, curY, topline}), 64'd0);
  endtask

  // ---------------- reference model (logical rows) ----------------
  int          mx, my, mt, mph, mr, mw;
  logic [7:0]  emem [0:2047];

  task automatic m_put(input int x, input int y, input int v);
    emem[addr_of(x, y)] = 8'(v);
    mw++;
  endtask

  task automatic m_blank_row(input int y, input int from);
    for (int x = from; x < 80; x++) m_put(x, y, 32);
  endtask

  task automatic m_lf();
    int l;
    l = (my - mt + 24) % 24;
    if (l < 23) my = (my + 1) % 24;
    else begin
      mt = (mt + 1) % 24;
      my = (mt + 23) % 24;
      m_blank_row(my, 0);
    end
  endtask

  task automatic m_byte(input logic [7:0] d);
    int b, c, l;
    b = int'(d[6:0]);
    case (mph)
      0: begin
        if (b >= 32 && b < 127) begin
          m_put(mx, my, b);
          if (mx < 79) mx++;
`ifdef VT_AUTOWRAP_EN
          else begin
            mx = 0;
            m_lf();
          end
`endif
        end else if (b == 13) mx = 0;
        else if (b == 10) m_lf();
        else if (b == 8) begin
          if (mx > 0) mx--;
        end else if (b == 9) mx = ((mx / 8 + 1) * 8 > 79) ? 79 : (mx / 8 + 1) * 8;
        else if (b == 27) mph = 1;
      end
      1: begin
        mph = 0;
        l = (my - mt + 24) % 24;
        case (b)
          65: if (l > 0) my = (my + 23) % 24;
          66: if (l < 23) my = (my + 1) % 24;
          67: if (mx < 79) mx++;
          68: if (mx > 0) mx--;
          72: begin mx = 0; my = mt; end
          74: begin
            m_blank_row(my, mx);
            for (int k = l + 1; k < 24; k++) m_blank_row((mt + k) % 24, 0);
          end
          75: m_blank_row(my, mx);
          89: mph = 2;
          default: ;
        endcase
      end
      2: begin
        mr  = b - 32;
        mph = 3;
      end
      default: begin
        c = b - 32;
        if (mr >= 0 && mr < 24) my = (mt + mr) % 24;
        if (c >= 0 && c < 80) mx = c;
        mph = 0;
      end
    endcase
  endtask

  function automatic logic [7:0] pick();
    int    r;
    string s;
    s = "ABCDHKYZx";
    r = $urandom_range(0, 99);
    case (mph)
      1: if (r < 3) return 8'h4A;
         else return s[$urandom_range(0, 8)];
      2: return 8'(32 + $urandom_range(0, 27));
      3: return 8'(32 + $urandom_range(0, 84));
      default: begin
        if (r < 45) return 8'(32 + $urandom_range(0, 95));
        if (r < 60) return 8'h0A;
        if (r < 67) return 8'h0D;
        if (r < 72) return 8'h08;
        if (r < 77) return 8'h09;
        if (r < 90) return 8'h1B;
        if (r < 95) return 8'($urandom_range(0, 31));
        return 8'(128 + $urandom_range(0, 127));
      end
    endcase
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] d;
    int ex, ey, et, nw, wa, wd;
  } vec_t;

  vec_t tv [38];

  initial begin
    int w0, lowc, nbad, fa;

    tv[0]  = '{8'h1B,  0, 0, 0, 0, 0, 0};
    tv[1]  = '{8'h59,  0, 0, 0, 0, 0, 0};
    tv[2]  = '{8'h22,  0, 0, 0, 0, 0, 0};
    tv[3]  = '{8'h25,  5, 2, 0, 0, 0, 0};
    tv[4]  = '{8'h51,  6, 2, 0, 1, 'h045, 'h51};
    tv[5]  = '{8'h1B,  6, 2, 0, 0, 0, 0};
    tv[6]  = '{8'h59,  6, 2, 0, 0, 0, 0};
    tv[7]  = '{8'h23,  6, 2, 0, 0, 0, 0};
    tv[8]  = '{8'h66, 70, 3, 0, 0, 0, 0};
    tv[9]  = '{8'h5A, 71, 3, 0, 1, 'h746, 'h5A};
    tv[10] = '{8'h0D,  0, 3, 0, 0, 0, 0};
    tv[11] = '{8'h09,  8, 3, 0, 0, 0, 0};
    tv[12] = '{8'h09, 16, 3, 0, 0, 0, 0};
    tv[13] = '{8'h08, 15, 3, 0, 0, 0, 0};
    tv[14] = '{8'h1B, 15, 3, 0, 0, 0, 0};
    tv[15] = '{8'h44, 14, 3, 0, 0, 0, 0};
    tv[16] = '{8'h1B, 14, 3, 0, 0, 0, 0};
    tv[17] = '{8'h43, 15, 3, 0, 0, 0, 0};
    tv[18] = '{8'h1B, 15, 3, 0, 0, 0, 0};
    tv[19] = '{8'h41, 15, 2, 0, 0, 0, 0};
    tv[20] = '{8'h1B, 15, 2, 0, 0, 0, 0};
    tv[21] = '{8'h48,  0, 0, 0, 0, 0, 0};
    tv[22] = '{8'h1B,  0, 0, 0, 0, 0, 0};
    tv[23] = '{8'h41,  0, 0, 0, 0, 0, 0};
    tv[24] = '{8'h07,  0, 0, 0, 0, 0, 0};
    tv[25] = '{8'hC1,  1, 0, 0, 1, 'h000, 'h41};
    tv[26] = '{8'h1B,  1, 0, 0, 0, 0, 0};
    tv[27] = '{8'h5A,  1, 0, 0, 0, 0, 0};
    tv[28] = '{8'h5A,  2, 0, 0, 1, 'h001, 'h5A};
    tv[29] = '{8'h1B,  2, 0, 0, 0, 0, 0};
    tv[30] = '{8'h59,  2, 0, 0, 0, 0, 0};
    tv[31] = '{8'h50,  2, 0, 0, 0, 0, 0};
    tv[32] = '{8'h2A, 10, 0, 0, 0, 0, 0};
    tv[33] = '{8'h1B, 10, 0, 0, 0, 0, 0};
    tv[34] = '{8'h59, 10, 0, 0, 0, 0, 0};
    tv[35] = '{8'h21, 10, 0, 0, 0, 0, 0};
    tv[36] = '{8'h7F, 10, 1, 0, 0, 0, 0};
    tv[37] = '{8'h7F, 10, 1, 0, 0, 0, 0};

    repeat (2) @(negedge clock);
    do_reset_check("por");

    foreach (tv[i]) begin
      w0 = wcount;
      send(tv[i].d, 1'b1);
      chk($sformatf("tv%0d_cursor", i), 64'({curX, curY, topline}),
          64'({7'(tv[i].ex), 5'(tv[i].ey), 5'(tv[i].et)}));
      chk($sformatf("tv%0d_nwrites", i), 64'(wcount - w0), 64'(tv[i].nw));
      if (tv[i].nw > 0)
        chk($sformatf("tv%0d_write", i), 64'({last_addr, last_data}),
            64'({11'(tv[i].wa), 8'(tv[i].wd)}));
    end

    // column 79 then two printables
    send(8'h1B, 1); send(8'h59, 1); send(8'h21, 1); send(8'h6F, 1);
    chk("c79_pos", 64'({curX, curY}), 64'({7'd79, 5'd1}));
    w0 = wcount;
    send(8'h61, 1);
    send(8'h62, 1);
    chk("c79_nwrites", 64'(wcount - w0), 64'd2);
`ifdef VT_AUTOWRAP_EN
    chk("c79_cursor", 64'({curX, curY}), 64'({7'd1, 5'd2}));
    chk("c79_b_addr", 64'(last_addr), 64'(addr_of(0, 2)));
    chk("c79_a_cell", 64'(shadow[addr_of(79, 1)]), 64'h61);
`else
    chk("c79_cursor", 64'({curX, curY}), 64'({7'd79, 5'd1}));
    chk("c79_b_addr", 64'(last_addr), 64'(addr_of(79, 1)));
    chk("c79_a_cell", 64'(shadow[addr_of(79, 1)]), 64'h62);
`endif

    // erase to end of line from column 10
    send(8'h1B, 1); send(8'h59, 1); send(8'h25, 1); send(8'h29, 1);
    send(8'h78, 1);
    w0 = wcount;
    send(8'h1B, 1); send(8'h4B, 1);
    chk("eol_nwrites", 64'(wcount - w0), 64'd70);
    chk("eol_cursor", 64'({curX, curY, topline}),
        64'({7'd10, 5'd5, 5'd0}));
    chk("eol_keep9", 64'(shadow[addr_of(9, 5)]), 64'h78);
    chk("eol_blank79", 64'(shadow[addr_of(79, 5)]), 64'h20);

    // line feeds down the screen, then a scroll
    send(8'h1B, 1); send(8'h48, 1);
    w0 = wcount;
    repeat (23) send(8'h0A, 1);
    chk("lf23_cursor", 64'({curX, curY, topline}), 64'({7'd0, 5'd23, 5'd0}));
    chk("lf23_nwrites", 64'(wcount - w0), 64'd0);
    send(8'h0A, 1'b0);
    lowc = 0;
    while (!char_ready && lowc < 200) begin
      lowc++;
      @(negedge clock);
    end
    chk("scroll_ready_low", 64'(lowc), 64'd80);
    chk("scroll_nwrites", 64'(wcount - w0), 64'd80);
    chk("scroll_cursor", 64'({curX, curY, topline}), 64'({7'd0, 5'd0, 5'd1}));
    chk("scroll_row0", 64'({shadow[addr_of(0, 0)], shadow[addr_of(1, 0)]}),
        64'h2020);
    chk("scroll_kept", 64'(shadow[addr_of(5, 2)]), 64'h51);

    // reset in the middle of a full-screen erase
    send(8'h1B, 1); send(8'h48, 1);
    chk("home_top1", 64'({curX, curY}), 64'({7'd0, 5'd1}));
    send(8'h1B, 1);
    send(8'h4A, 1'b0);
    repeat (100) @(negedge clock);
    chk("midclr_active", 64'({char_ready, mem_we}), 64'b01);
    do_reset_check("midclr");

    // random bytes against the model
    mx = 0; my = 0; mt = 0; mph = 0; mr = 0; mw = 0;
    for (int i = 0; i < 2048; i++) emem[i] = 8'h20;
    wcount = 0;
    for (int i = 0; i < 400; i++) begin
      logic [7:0] d;
      d = pick();
      send(d, 1'b1);
      m_byte(d);
      chk($sformatf("rnd%0d_cursor(byte %02h)", i, d),
          64'({curX, curY, topline}),
          64'({7'(mx), 5'(my), 5'(mt)}));
      chk($sformatf("rnd%0d_nwrites", i), 64'(wcount), 64'(mw));
    end

    nbad = 0;
    fa = -1;
    for (int y = 0; y < 24; y++)
      for (int x = 0; x < 80; x++)
        if (shadow[addr_of(x, y)] !== emem[addr_of(x, y)]) begin
          nbad++;
          if (fa < 0) fa = addr_of(x, y);
        end
    if (nbad != 0) $display("first differing cell at address 0x%0h", fa);
    chk("screen_image_diffs", 64'(nbad), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end

endmodule
